// File: rtl/sw_input_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// sw_input_conditioner_pkg
// Shared definitions for the slide-switch input conditioner:
//   - deb_state_e              : per-bit debounce FSM state encoding
//   - NB_DEBOUNCE_DEFAULT      : counter width for the 100 MHz board clock
//   - DEBOUNCE_CYCLES_DEFAULT  : 10 ms settle time at 100 MHz
// No ports (package).
// ---------------------------------------------------------------------------
package sw_input_conditioner_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } deb_state_e;

  localparam int NB_DEBOUNCE_DEFAULT     = 20;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/sw_input_conditioner_debounce_bit.sv
// ---------------------------------------------------------------------------
// sw_input_conditioner_debounce_bit
// One switch bit: 2-FF synchroniser, debounce FSM and settle counter.
// A new level must sit on the synchronised input for DEBOUNCE_CYCLES
// consecutive cycles before it is accepted as the stable level.
// Ports:
//   clock     in  system clock
//   reset_i   in  synchronous active-high reset
//   sw_i      in  raw asynchronous switch level
//   stable_o  out debounced level (registered)
//   rise_o    out one-cycle strobe, coincides with stable_o going 0->1
//   fall_o    out one-cycle strobe, coincides with stable_o going 1->0
//   change_o  out combinational: stable_o flips at the coming edge
// ---------------------------------------------------------------------------
module sw_input_conditioner_debounce_bit
  import sw_input_conditioner_pkg::*;
#(
  parameter int NB_DEBOUNCE     = NB_DEBOUNCE_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset_i,
  input  logic sw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o,
  output logic change_o
);

  localparam logic [NB_DEBOUNCE-1:0] CNT_LAST = NB_DEBOUNCE'(DEBOUNCE_CYCLES - 1);

  logic                   sync1_q;
  logic                   sync2_q;
  logic                   stable_q;
  logic                   rise_q;
  logic                   fall_q;
  deb_state_e             state_q;
  logic [NB_DEBOUNCE-1:0] cnt_q;
  logic                   differs;

  assign differs = (sync2_q != stable_q);

  // Next-state decode of an acceptance, so the top can update its event
  // register in the same edge that the stable level and strobes change.
  assign change_o = (state_q == ST_SETTLE) && differs && (cnt_q == CNT_LAST);

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

  // Synchroniser, settle counter and FSM. The counter holds 1 on entry to
  // SETTLE, so reaching CNT_LAST with the level still differing means the
  // new level has been seen for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clock) begin
    if (reset_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (differs) begin
            state_q <= ST_SETTLE;
            cnt_q   <= NB_DEBOUNCE'(1);
          end
        end
        ST_SETTLE: begin
          if (!differs) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            stable_q <= sync2_q;
            rise_q   <= sync2_q;
            fall_q   <= ~sync2_q;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sw_input_conditioner.sv
// ---------------------------------------------------------------------------
// sw_input_conditioner
// Conditions the board slide switches: per-bit synchronise + debounce, with
// rise/fall strobes, and offers every accepted change as a snapshot over a
// valid/ack event handshake.
// Ports:
//   clock          in   system clock
//   i_reset        in   synchronous active-high reset
//   i_sw           in   raw asynchronous switch levels [NB_SW]
//   o_sw_stable    out  debounced switch levels [NB_SW]
//   o_sw_rise      out  1-cycle pulse per bit on accepted 0->1 [NB_SW]
//   o_sw_fall      out  1-cycle pulse per bit on accepted 1->0 [NB_SW]
//   o_evt_valid    out  change event pending
//   o_evt_data     out  snapshot of the stable bus for the pending event
//   i_evt_ack      in   consumer accepts the event (only meaningful when valid)
//   o_evt_overrun  out  sticky: a change replaced an un-acked event
// ---------------------------------------------------------------------------
module sw_input_conditioner
  import sw_input_conditioner_pkg::*;
#(
  parameter int NB_SW           = 4,
  parameter int NB_DEBOUNCE     = NB_DEBOUNCE_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [NB_SW-1:0] i_sw,
  output logic [NB_SW-1:0] o_sw_stable,
  output logic [NB_SW-1:0] o_sw_rise,
  output logic [NB_SW-1:0] o_sw_fall,
  output logic             o_evt_valid,
  output logic [NB_SW-1:0] o_evt_data,
  input  logic             i_evt_ack,
  output logic             o_evt_overrun
);

  logic [NB_SW-1:0] bitChange;
  logic [NB_SW-1:0] stableNext;
  logic             upd;
  logic             evtValid_q;
  logic [NB_SW-1:0] evtData_q;
  logic             evtOverrun_q;

  for (genvar g = 0; g < NB_SW; g++) begin : gen_bit
    sw_input_conditioner_debounce_bit #(
      .NB_DEBOUNCE     (NB_DEBOUNCE),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clock    (clock),
      .reset_i  (i_reset),
      .sw_i     (i_sw[g]),
      .stable_o (o_sw_stable[g]),
      .rise_o   (o_sw_rise[g]),
      .fall_o   (o_sw_fall[g]),
      .change_o (bitChange[g])
    );
  end

  // An accepted change always flips the stable bit, so XOR gives the value
  // the stable bus takes at the coming edge.
  assign stableNext = o_sw_stable ^ bitChange;
  assign upd        = |bitChange;

  // Event handshake. A new change always loads the latest snapshot; it is
  // an overrun only if the previous event is still pending and not being
  // acked in this same cycle. Ack with nothing pending is ignored.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      evtValid_q   <= 1'b0;
      evtData_q    <= '0;
      evtOverrun_q <= 1'b0;
    end else if (upd) begin
      evtValid_q <= 1'b1;
      evtData_q  <= stableNext;
      if (evtValid_q && !i_evt_ack) begin
        evtOverrun_q <= 1'b1;
      end
    end else if (evtValid_q && i_evt_ack) begin
      evtValid_q <= 1'b0;
    end
  end

  assign o_evt_valid   = evtValid_q;
  assign o_evt_data    = evtData_q;
  assign o_evt_overrun = evtOverrun_q;

endmodule

// File: tb/tb_sw_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_sw_input_conditioner
// Directed bench for sw_input_conditioner with DEBOUNCE_CYCLES=8,
// NB_DEBOUNCE=4 and a 10 ns clock. Expected values are hand-computed:
// a level present before edge 0 is accepted at edge 9.
// ---------------------------------------------------------------------------
module tb_sw_input_conditioner;

  localparam int NB_SW           = 4;
  localparam int NB_DEBOUNCE     = 4;
  localparam int DEBOUNCE_CYCLES = 8;

  logic             clock = 1'b0;
  logic             i_reset;
  logic [NB_SW-1:0] i_sw;
  logic             i_evt_ack;
  logic [NB_SW-1:0] o_sw_stable;
  logic [NB_SW-1:0] o_sw_rise;
  logic [NB_SW-1:0] o_sw_fall;
  logic             o_evt_valid;
  logic [NB_SW-1:0] o_evt_data;
  logic             o_evt_overrun;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clock = ~clock;

  sw_input_conditioner #(
    .NB_SW           (NB_SW),
    .NB_DEBOUNCE     (NB_DEBOUNCE),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clock         (clock),
    .i_reset       (i_reset),
    .i_sw          (i_sw),
    .o_sw_stable   (o_sw_stable),
    .o_sw_rise     (o_sw_rise),
    .o_sw_fall     (o_sw_fall),
    .o_evt_valid   (o_evt_valid),
    .o_evt_data    (o_evt_data),
    .i_evt_ack     (i_evt_ack),
    .o_evt_overrun (o_evt_overrun)
  );

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance one clock and settle 1 ns past the edge before sampling/driving.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic [NB_SW-1:0] sw, input logic ack);
    i_reset   = rst;
    i_sw      = sw;
    i_evt_ack = ack;
  endtask

  task automatic checkAll(input string tag, input logic [NB_SW-1:0] stable,
                          input logic [NB_SW-1:0] rise, input logic [NB_SW-1:0] fall,
                          input logic valid, input logic [NB_SW-1:0] data,
                          input logic overrun);
    checkOutput({tag, ".stable"},  32'(o_sw_stable),   32'(stable));
    checkOutput({tag, ".rise"},    32'(o_sw_rise),     32'(rise));
    checkOutput({tag, ".fall"},    32'(o_sw_fall),     32'(fall));
    checkOutput({tag, ".valid"},   32'(o_evt_valid),   32'(valid));
    checkOutput({tag, ".data"},    32'(o_evt_data),    32'(data));
    checkOutput({tag, ".overrun"}, 32'(o_evt_overrun), 32'(overrun));
  endtask

  // Tick n times, expecting no strobes and an unchanged event register.
  task automatic holdStable(input string tag, input int n, input logic [NB_SW-1:0] stable,
                            input logic valid, input logic [NB_SW-1:0] data,
                            input logic overrun);
    for (int i = 0; i < n; i++) begin
      tick();
      checkAll(tag, stable, 4'h0, 4'h0, valid, data, overrun);
    end
  endtask

  task automatic doReset(input string tag);
    applyStimulus(1'b1, 4'h0, 1'b0);
    tick();
    tick();
    checkAll(tag, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    // Test 1: reset held with all switches on, then full latency.
    applyStimulus(1'b1, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkAll("t1.rst", 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    end
    applyStimulus(1'b0, 4'hF, 1'b0);
    holdStable("t1.settle", 9, 4'h0, 1'b0, 4'h0, 1'b0);
    tick();
    checkAll("t1.accept", 4'hF, 4'hF, 4'h0, 1'b1, 4'hF, 1'b0);
    applyStimulus(1'b0, 4'hF, 1'b1);
    tick();
    checkAll("t1.ack", 4'hF, 4'h0, 4'h0, 1'b0, 4'hF, 1'b0);

    // Test 2: single bit rise and ack.
    doReset("t2.rst");
    applyStimulus(1'b0, 4'h1, 1'b0);
    holdStable("t2.settle", 9, 4'h0, 1'b0, 4'h0, 1'b0);
    tick();
    checkAll("t2.accept", 4'h1, 4'h1, 4'h0, 1'b1, 4'h1, 1'b0);
    applyStimulus(1'b0, 4'h1, 1'b1);
    tick();
    checkAll("t2.ack", 4'h1, 4'h0, 4'h0, 1'b0, 4'h1, 1'b0);
    applyStimulus(1'b0, 4'h1, 1'b0);

    // Test 3: 5-cycle glitch rejected, 8-cycle pulse accepted (rise then fall).
    applyStimulus(1'b0, 4'h3, 1'b0);
    holdStable("t3.glitch", 5, 4'h1, 1'b0, 4'h1, 1'b0);
    applyStimulus(1'b0, 4'h1, 1'b0);
    holdStable("t3.reject", 15, 4'h1, 1'b0, 4'h1, 1'b0);
    applyStimulus(1'b0, 4'h3, 1'b0);
    holdStable("t3.pulse", 8, 4'h1, 1'b0, 4'h1, 1'b0);
    applyStimulus(1'b0, 4'h1, 1'b0);
    holdStable("t3.edge8", 1, 4'h1, 1'b0, 4'h1, 1'b0);
    tick();
    checkAll("t3.rise", 4'h3, 4'h2, 4'h0, 1'b1, 4'h3, 1'b0);
    applyStimulus(1'b0, 4'h1, 1'b1);
    tick();
    checkAll("t3.ack1", 4'h3, 4'h0, 4'h0, 1'b0, 4'h3, 1'b0);
    applyStimulus(1'b0, 4'h1, 1'b0);
    holdStable("t3.fallsettle", 6, 4'h3, 1'b0, 4'h3, 1'b0);
    tick();
    checkAll("t3.fall", 4'h1, 4'h0, 4'h2, 1'b1, 4'h1, 1'b0);
    applyStimulus(1'b0, 4'h1, 1'b1);
    tick();
    checkAll("t3.ack2", 4'h1, 4'h0, 4'h0, 1'b0, 4'h1, 1'b0);
    applyStimulus(1'b0, 4'h1, 1'b0);

    // Test 4: second change with no ack sets sticky overrun.
    doReset("t4.rst");
    applyStimulus(1'b0, 4'h1, 1'b0);
    holdStable("t4.settle1", 9, 4'h0, 1'b0, 4'h0, 1'b0);
    tick();
    checkAll("t4.first", 4'h1, 4'h1, 4'h0, 1'b1, 4'h1, 1'b0);
    applyStimulus(1'b0, 4'h3, 1'b0);
    holdStable("t4.settle2", 9, 4'h1, 1'b1, 4'h1, 1'b0);
    tick();
    checkAll("t4.second", 4'h3, 4'h2, 4'h0, 1'b1, 4'h3, 1'b1);
    applyStimulus(1'b0, 4'h3, 1'b1);
    tick();
    checkAll("t4.ack", 4'h3, 4'h0, 4'h0, 1'b0, 4'h3, 1'b1);
    applyStimulus(1'b0, 4'h3, 1'b0);
    tick();
    checkAll("t4.sticky", 4'h3, 4'h0, 4'h0, 1'b0, 4'h3, 1'b1);

    // Test 5: ack in the same cycle as a new update: no overrun.
    doReset("t5.rst");
    applyStimulus(1'b0, 4'h1, 1'b0);
    holdStable("t5.settle1", 9, 4'h0, 1'b0, 4'h0, 1'b0);
    tick();
    checkAll("t5.first", 4'h1, 4'h1, 4'h0, 1'b1, 4'h1, 1'b0);
    applyStimulus(1'b0, 4'h5, 1'b0);
    holdStable("t5.settle2", 9, 4'h1, 1'b1, 4'h1, 1'b0);
    applyStimulus(1'b0, 4'h5, 1'b1);
    tick();
    checkAll("t5.simul", 4'h5, 4'h4, 4'h0, 1'b1, 4'h5, 1'b0);
    tick();
    checkAll("t5.ack", 4'h5, 4'h0, 4'h0, 1'b0, 4'h5, 1'b0);
    applyStimulus(1'b0, 4'h5, 1'b0);

    // Test 6: reset mid-settle restarts the full latency.
    doReset("t6.rst");
    applyStimulus(1'b0, 4'h8, 1'b0);
    holdStable("t6.partial", 7, 4'h0, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b1, 4'h8, 1'b0);
    tick();
    checkAll("t6.midrst", 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b0, 4'h8, 1'b0);
    holdStable("t6.restart", 9, 4'h0, 1'b0, 4'h0, 1'b0);
    tick();
    checkAll("t6.accept", 4'h8, 4'h8, 4'h0, 1'b1, 4'h8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
